// File: rtl/sprite_pkg.sv
// Shared encodings for the fighter sprite animation path.
//   character_state codes, move_state codes, frame limits, the FSM state type,
//   and the registered output bundle driven by sprite_anim_sequencer.
package sprite_pkg;

  localparam int unsigned CS_W    = 3;
  localparam int unsigned MS_W    = 2;
  localparam int unsigned FRAME_W = 2;

  localparam logic [CS_W-1:0] CS_IDLE  = 3'b000;
  localparam logic [CS_W-1:0] CS_PUNCH = 3'b001;
  localparam logic [CS_W-1:0] CS_INJ   = 3'b010;

  localparam logic [MS_W-1:0] MS_STAND = 2'b00;
  localparam logic [MS_W-1:0] MS_FWD   = 2'b01;
  localparam logic [MS_W-1:0] MS_BACK  = 2'b10;

  localparam logic [FRAME_W-1:0] LAST_FRAME = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUNCH = 2'd1,
    ST_INJ   = 2'd2
  } anim_state_e;

  // Registered outputs toward the sprite colour path.
  typedef struct packed {
    logic [CS_W-1:0]    character_state;
    logic [MS_W-1:0]    move_state;
    logic [FRAME_W-1:0] frame;
    logic               busy;
    logic               action_done;
  } anim_out_t;

  // First frame of a punch or injury sequence.
  function automatic anim_out_t seq_start(input logic [CS_W-1:0] cs);
    seq_start = '{character_state: cs, move_state: MS_STAND,
                  frame: FRAME_W'(0), busy: 1'b1, action_done: 1'b0};
  endfunction

  // Normal completion of a sequence: back to standing idle, one done pulse.
  function automatic anim_out_t seq_end();
    seq_end = '{character_state: CS_IDLE, move_state: MS_STAND,
                frame: FRAME_W'(0), busy: 1'b0, action_done: 1'b1};
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-rate tick generator: one-cycle tick every TICK_DIV clk cycles.
//   clk, rst_n : clock, async active-low reset
//   tick       : high in the cycle the counter sits at TICK_DIV-1
module frame_tick_gen #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Decode of a flop, so the tick is clean and aligned to the wrap.
  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Per-fighter animation sequencer: arbitrates hit/attack/move requests and
// steps punch and injury frame sequences on a shared frame tick.
//   attack_req, hit_req : level inputs, rising edge = request
//   move_fwd, move_back : walking direction levels
//   character_state, move_state, frame, busy : registered sprite selects
//   action_done : one-cycle pulse on normal sequence completion
//   frame_tick  : exported frame-rate pulse
module sprite_anim_sequencer
  import sprite_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                attack_req,
  input  logic                hit_req,
  input  logic                move_fwd,
  input  logic                move_back,
  output logic [CS_W-1:0]     character_state,
  output logic [MS_W-1:0]     move_state,
  output logic [FRAME_W-1:0]  frame,
  output logic                busy,
  output logic                action_done,
  output logic                frame_tick
);

  logic        tick;
  anim_state_e state_q, state_d;
  anim_out_t   out_q, out_d;
  logic        atk_prev_q, hit_prev_q;
  logic        atk_pend_q, atk_pend_d;
  logic        hit_pend_q, hit_pend_d;
  logic        atk_rise, hit_rise;
  logic        atk_clr, hit_clr;

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign frame_tick      = tick;
  assign character_state = out_q.character_state;
  assign move_state      = out_q.move_state;
  assign frame           = out_q.frame;
  assign busy            = out_q.busy;
  assign action_done     = out_q.action_done;

  assign atk_rise = attack_req & ~atk_prev_q;
  assign hit_rise = hit_req & ~hit_prev_q;

  // Next-state, next-output and pend-flag clear decisions; only ticks move the FSM.
  always_comb begin
    state_d           = state_q;
    out_d             = out_q;
    out_d.action_done = 1'b0;
    atk_clr           = 1'b0;
    hit_clr           = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (hit_pend_q) begin
            // Hit outranks attack; a pending attack is dropped with it.
            state_d = ST_INJ;
            out_d   = seq_start(CS_INJ);
            hit_clr = 1'b1;
            atk_clr = 1'b1;
          end else if (atk_pend_q) begin
            state_d = ST_PUNCH;
            out_d   = seq_start(CS_PUNCH);
            atk_clr = 1'b1;
          end else begin
            case ({move_fwd, move_back})
              2'b10: begin
                out_d.move_state = MS_FWD;
                out_d.frame      = (out_q.frame == FRAME_W'(0)) ? FRAME_W'(1) : FRAME_W'(0);
              end
              2'b01: begin
                out_d.move_state = MS_BACK;
                out_d.frame      = (out_q.frame == FRAME_W'(0)) ? FRAME_W'(2) : FRAME_W'(0);
              end
              default: begin
                out_d.move_state = MS_STAND;
                out_d.frame      = FRAME_W'(0);
              end
            endcase
          end
        end
        ST_PUNCH: begin
          // No queued combos: an attack raised mid-punch is thrown away.
          atk_clr = 1'b1;
          if (hit_pend_q) begin
            state_d = ST_INJ;
            out_d   = seq_start(CS_INJ);
            hit_clr = 1'b1;
          end else if (out_q.frame == LAST_FRAME) begin
            state_d = ST_IDLE;
            out_d   = seq_end();
          end else begin
            out_d.frame = out_q.frame + FRAME_W'(1);
          end
        end
        ST_INJ: begin
          // Hit-stun: every request seen during injury is discarded.
          atk_clr = 1'b1;
          hit_clr = 1'b1;
          if (out_q.frame == LAST_FRAME) begin
            state_d = ST_IDLE;
            out_d   = seq_end();
          end else begin
            out_d.frame = out_q.frame + FRAME_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          out_d   = '0;
        end
      endcase
    end
    // A clear also swallows an edge arriving in the same cycle.
    atk_pend_d = atk_clr ? 1'b0 : (atk_pend_q | atk_rise);
    hit_pend_d = hit_clr ? 1'b0 : (hit_pend_q | hit_rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      out_q      <= '0;
      atk_prev_q <= 1'b0;
      hit_prev_q <= 1'b0;
      atk_pend_q <= 1'b0;
      hit_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      atk_prev_q <= attack_req;
      hit_prev_q <= hit_req;
      atk_pend_q <= atk_pend_d;
      hit_pend_q <= hit_pend_d;
    end
  end

endmodule

// File: doc/sprite_anim_sequencer.md
# sprite_anim_sequencer

Sequences one fighter's animation state for the sprite renderer. It arbitrates hit, attack and movement requests and steps through punch and injury frame sequences at a fixed frame rate. It drives the `character_state`, `move_state` and frame-select inputs that select which sprite ROM colour is shown. It sits between the player/game logic and the sprite colour path, one instance per fighter, and replaces the free-running per-sprite 4 Hz clocks with one synchronous frame tick.

## Interface
- `TICK_DIV`, 12_500_000, clk cycles per animation frame tick (4 Hz at 50 MHz); minimum 2.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `attack_req`  in  1  level; rising edge requests a normal attack.
- `hit_req`  in  1  level; rising edge reports that this fighter was hit.
- `move_fwd`  in  1  level; walking forward.
- `move_back`  in  1  level; walking backward.
- `character_state`  out  3  000 idle/walk, 001 punch, 010 injured; other codes are never driven.
- `move_state`  out  2  00 stand, 01 forward, 10 backward; always 00 outside idle.
- `frame`  out  2  frame index within the current sequence.
- `busy`  out  1  high while in punch or injured.
- `action_done`  out  1  one-cycle pulse when a sequence completes normally.
- `frame_tick`  out  1  one-cycle pulse per frame, exported for other animators.

## Operation
- **Tick generator:** counter 0..TICK_DIV-1. `frame_tick`=1 in the cycle the counter equals TICK_DIV-1, and the counter wraps to 0 there.
- **Edge detection:** registered previous copies of `attack_req` and `hit_req`.
  - A rising edge sets `atk_pend` or `hit_pend`.
  - A pend flag is held until it is consumed or discarded on a tick.
- **FSM states:** IDLE, PUNCH, INJ. All transitions happen only in `frame_tick` cycles.
- **IDLE:**
  - If `hit_pend`: go to INJ with frame 0.
  - Else if `atk_pend`: go to PUNCH with frame 0.
  - Else walk:
    - `move_fwd` only: `move_state`=01, frame toggles 0↔1.
    - `move_back` only: `move_state`=10, frame toggles 0↔2.
    - Neither, or both: `move_state`=00, frame=0.
- **PUNCH:**
  - Frame advances 0→1→2→3 on successive ticks.
  - On the tick in frame 3: go to IDLE, frame 0, and pulse `action_done`.
  - `hit_pend` on any PUNCH tick preempts: go to INJ with frame 0, and no `action_done`.
  - `atk_pend` arriving during PUNCH is discarded on each PUNCH tick (no queued combos).
- **INJ:**
  - Frame advances 0→1→2→3.
  - On the tick in frame 3: go to IDLE, frame 0, and pulse `action_done`.
  - `hit_pend` and `atk_pend` are discarded on every INJ tick (hit-stun invulnerability).
- **Consume and discard rule:** a flag consumed or discarded on a tick is cleared. A rising edge in that same cycle is treated as the request just consumed, and is not re-queued.
- **Outputs:** `character_state`, `move_state`, `frame` and `busy` are registered and decoded from the FSM.

## Timing
- **Reset values:** all outputs 0, state IDLE, tick counter 0, pend flags 0, edge registers 0.
- **Latency:**
  - Outputs change in the cycle after the `frame_tick` cycle.
  - A request edge reaches `character_state` within TICK_DIV+1 cycles.
- **`action_done`:** asserted in the same cycle that `character_state` returns to 000.
- **Sequence length:** each sequence holds exactly 4 ticks, the last being the return-to-normal frame 3.
- **Reset mid-sequence:** immediately returns to IDLE/frame 0. The tick phase restarts from 0 and pending requests are lost.
- **Simultaneous hit and attack edges:** hit wins and the attack is discarded.

## Structure
- **Shared package `sprite_pkg`:**
  - `character_state` codes (CS_IDLE, CS_PUNCH, CS_INJ).
  - `move_state` codes (MS_STAND, MS_FWD, MS_BACK).
  - The LAST_FRAME=3 constant.
- **Sub-module `frame_tick_gen`:** parameter TICK_DIV; ports `clk`, `rst_n`, `tick`. Also reusable for HUD blink.
- **Top-level content:** the edge detectors, pend flags and FSM live in the top module.

## Test plan
All scenarios run with TICK_DIV=4.
1. **Reset:** hold `rst_n`=0 across ticks → all outputs 0. After release, `frame_tick` pulses every 4 cycles, first at cycle 4.
2. **Walk:**
   - `move_fwd`=1 → `move_state`=01 and frame 1,0,1,0 on successive ticks.
   - Switch to `move_back` → frame 2,0,2.
   - Both high → 00/0.
3. **Attack:**
   - One `attack_req` edge → `character_state`=001 with frames 0,1,2,3 over 4 ticks, `busy`=1.
   - Then 000/0 with a single `action_done` pulse.
4. **Preempt:** attack, then a `hit_req` edge at PUNCH frame 1 → next tick gives 010/frame 0, no `action_done`. INJ completes 4 ticks and then `action_done` pulses.
5. **Invulnerability and drop:** extra `hit_req` and `attack_req` edges during INJ → no restart, and IDLE persists after completion.
6. **Same-cycle and async reset:**
   - Attack and hit edges in the same cycle → INJ only.
   - `rst_n` low at PUNCH frame 2 → outputs 0 immediately, without waiting for a clock edge.
